dma_cmd_scheduler: RTL and testbench

- Shares one DMA engine among NUM_REQ command initiators.
- Each initiator offers a copy command (src, dst, len) on a valid/ready channel.
- A round-robin arbiter picks one command and issues it to the DMA target, then waits for done.
- A watchdog aborts hung transfers. Completion status returns to the owning initiator.

---
 rtl/dma_cmd_types_pkg.sv | 32 +++
 rtl/dma_cmd_scheduler_rr_arbiter.sv | 37 +++
 rtl/dma_cmd_scheduler.sv | 141 ++++++++++++++
 tb/tb_dma_cmd_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_cmd_types_pkg.sv
// dma_cmd_types_pkg: shared types for the DMA command scheduler.
//   dma_cmd_t     - latched copy command (source, destination, byte length)
//   sched_state_e - scheduler FSM states
//   cpl_status_e  - completion status returned to the owning initiator
// The command struct is sized by CMD_ADDR_W/CMD_LEN_W; scheduler instances
// must use address/length widths no larger than these.
package dma_cmd_types_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_LEN_W  = 16;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] src;
        logic [CMD_ADDR_W-1:0] dst;
        logic [CMD_LEN_W-1:0]  len;
    } dma_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_CPL
    } sched_state_e;

    typedef enum logic [1:0] {
        CPL_OK      = 2'b00,
        CPL_DMA_ERR = 2'b01,
        CPL_TIMEOUT = 2'b10
    } cpl_status_e;

endpackage

// File: rtl/dma_cmd_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or
// after a pointer, wrapping around.
//   req_i  - request vector
//   ptr_i  - highest-priority index this round
//   gnt_o  - one-hot grant (zero when no request)
//   idx_o  - index of the granted request
//   any_o  - at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = IW'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = j;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_cmd_scheduler.sv
// dma_cmd_scheduler: shares one DMA engine among NUM_REQ initiators with
// round-robin arbitration, a completion watchdog and per-initiator status.
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   req_valid/ready  - per-initiator command handshake (ready one-hot or zero)
//   req_src/dst/len  - packed per-initiator command fields, slice i = initiator i
//   dma_cmd_valid/ready, dma_src/dst/len - command issued to the DMA engine
//   dma_done, dma_err - transfer-complete pulse and its error qualifier
//   dma_abort        - one-cycle abort pulse when the watchdog expires
//   cpl_valid        - one-hot completion pulse to the owning initiator
//   cpl_status       - 00 ok, 01 dma error, 10 timeout (valid with cpl_valid)
//   busy, owner      - scheduler not idle, index of the current grantee
module dma_cmd_scheduler
    import dma_cmd_types_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_src,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_dst,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic                       dma_cmd_valid,
    input  logic                       dma_cmd_ready,
    output logic [ADDR_W-1:0]          dma_src,
    output logic [ADDR_W-1:0]          dma_dst,
    output logic [LEN_W-1:0]           dma_len,
    input  logic                       dma_done,
    input  logic                       dma_err,
    output logic                       dma_abort,
    output logic [NUM_REQ-1:0]         cpl_valid,
    output logic [1:0]                 cpl_status,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);

    sched_state_e  state_q, state_d;
    dma_cmd_t      cmd_q, cmd_d;
    cpl_status_e   status_q, status_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [31:0]        gsel;
    logic [LEN_W-1:0]   sel_len;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign gsel    = 32'(gnt_idx);
    assign sel_len = req_len[gsel*LEN_W +: LEN_W];

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        status_d = status_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE: if (gnt_any) begin
                owner_d   = gnt_idx;
                cmd_d.src = CMD_ADDR_W'(req_src[gsel*ADDR_W +: ADDR_W]);
                cmd_d.dst = CMD_ADDR_W'(req_dst[gsel*ADDR_W +: ADDR_W]);
                cmd_d.len = CMD_LEN_W'(sel_len);
                status_d  = CPL_OK;
                // A zero-length copy completes without touching the DMA engine.
                state_d   = (sel_len == '0) ? S_CPL : S_ISSUE;
            end
            S_ISSUE: if (dma_cmd_ready) begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // Done takes priority over a simultaneous timeout.
                if (dma_done) begin
                    state_d  = S_CPL;
                    status_d = dma_err ? CPL_DMA_ERR : CPL_OK;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                state_d  = S_CPL;
                status_d = CPL_TIMEOUT;
            end
            S_CPL: begin
                state_d = S_IDLE;
                ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            status_q <= CPL_OK;
            owner_q  <= '0;
            ptr_q    <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            status_q <= status_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
        end
    end

    // Gating with rst_n keeps every output at zero while reset is held.
    assign req_ready     = (state_q == S_IDLE && rst_n) ? gnt : '0;
    assign dma_cmd_valid = state_q == S_ISSUE;
    assign dma_src       = ADDR_W'(cmd_q.src);
    assign dma_dst       = ADDR_W'(cmd_q.dst);
    assign dma_len       = LEN_W'(cmd_q.len);
    assign dma_abort     = state_q == S_ABORT;
    assign cpl_valid     = (state_q == S_CPL) ? NUM_REQ'(1) << owner_q : '0;
    assign cpl_status    = (state_q == S_CPL) ? status_q : 2'b00;
    assign busy          = state_q != S_IDLE;
    assign owner         = owner_q;

endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// tb_dma_cmd_scheduler: scoreboard bench for dma_cmd_scheduler with a small DMA responder model.
module tb_dma_cmd_scheduler;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int TO = 16;

    logic            clk, rst_n;
    logic [N-1:0]    req_valid, req_ready, cpl_valid;
    logic [N*AW-1:0] req_src, req_dst;
    logic [N*LW-1:0] req_len;
    logic            dma_cmd_valid, dma_cmd_ready, dma_done, dma_err, dma_abort, busy;
    logic [AW-1:0]   dma_src, dma_dst;
    logic [LW-1:0]   dma_len;
    logic [1:0]      cpl_status;
    logic [1:0]      owner;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } cmd_t;

    typedef struct {
        logic [3:0] vld;
        logic [1:0] st;
        int         lat;
    } cpl_t;

    cmd_t exp_cmd[$];
    cpl_t exp_cpl[$];
    int   gnt_log[$];
    cmd_t ec;
    cpl_t ep;

    int vectors = 0, miscompares = 0;
    int cyc = 0, last_grant = 0, wait_start = 0, aborts = 0, exp_aborts = 0;
    bit prev_abort = 0, prev_valid = 0;
    int ready_dly = 0, done_dly = 0;
    bit withhold = 0, err_flag = 0;

    logic [31:0] srcs[4] = '{32'h0000_A000, 32'h0000_A100, 32'h0000_A200, 32'h0000_A300};
    logic [31:0] dsts[4] = '{32'h0000_B000, 32'h0000_B100, 32'h0000_B200, 32'h0000_B300};
    logic [15:0] lens[4] = '{16'd8, 16'd16, 16'd24, 16'd32};
    int          ord[5]  = '{0, 1, 2, 3, 0};

    dma_cmd_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_len       (req_len),
        .dma_cmd_valid (dma_cmd_valid),
        .dma_cmd_ready (dma_cmd_ready),
        .dma_src       (dma_src),
        .dma_dst       (dma_dst),
        .dma_len       (dma_len),
        .dma_done      (dma_done),
        .dma_err       (dma_err),
        .dma_abort     (dma_abort),
        .cpl_valid     (cpl_valid),
        .cpl_status    (cpl_status),
        .busy          (busy),
        .owner         (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        cmd_t e;
        e.src = s;
        e.dst = d;
        e.len = l;
        exp_cmd.push_back(e);
    endtask

    task automatic push_cpl(input logic [3:0] v, input logic [1:0] s, input int l);
        cpl_t e;
        e.vld = v;
        e.st  = s;
        e.lat = l;
        exp_cpl.push_back(e);
    endtask

    task automatic set_cmd(input int i, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        req_src[i*AW +: AW] = s;
        req_dst[i*AW +: AW] = d;
        req_len[i*LW +: LW] = l;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise the requests in mask and wait for n handshakes; with keep=0 each
    // requester drops right after its grant, with keep=1 all stay up until n.
    task automatic serve(input logic [N-1:0] mask, input int n, input bit keep);
        int got = 0;
        logic [N-1:0] r;
        req_valid = mask;
        for (int k = 0; k < 200 && got < n; k++) begin
            #1;
            r = req_ready;
            @(posedge clk);
            #1;
            if (r != 0) begin
                got++;
                if (!keep) req_valid = req_valid & ~r;
            end
        end
        req_valid = '0;
        check("grants_seen", got, n);
    endtask

    task automatic drain(input string name, input int maxc);
        int k = 0;
        while ((exp_cpl.size() != 0 || busy) && k < maxc) begin
            tick(1);
            k++;
        end
        check({name, "_pending_cpl"}, exp_cpl.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    // DMA responder: accepts a command after ready_dly cycles, then pulses
    // done done_dly cycles into WAIT unless withhold is set.
    initial begin : dma_model
        dma_cmd_ready = 1'b0;
        dma_done      = 1'b0;
        dma_err       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && dma_cmd_valid) begin
                repeat (ready_dly) begin
                    @(posedge clk);
                    #1;
                end
                dma_cmd_ready = 1'b1;
                @(posedge clk);
                #1;
                dma_cmd_ready = 1'b0;
                if (!withhold) begin
                    repeat (done_dly) begin
                        @(posedge clk);
                        #1;
                    end
                    dma_done = 1'b1;
                    dma_err  = err_flag;
                    @(posedge clk);
                    #1;
                    dma_done = 1'b0;
                    dma_err  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 0) begin
                check("req_ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < N; i++) if (req_ready[i]) gnt_log.push_back(i);
                last_grant = cyc;
            end
            if (dma_cmd_valid && !prev_valid) check("cmd_valid_latency", cyc - last_grant, 1);
            if (dma_cmd_valid) begin
                if (exp_cmd.size() == 0) check("dma_cmd_unexpected", dma_cmd_valid, 0);
                else begin
                    check("dma_src", dma_src, exp_cmd[0].src);
                    check("dma_dst", dma_dst, exp_cmd[0].dst);
                    check("dma_len", dma_len, exp_cmd[0].len);
                    if (dma_cmd_ready) begin
                        ec = exp_cmd.pop_front();
                        wait_start = cyc + 1;
                    end
                end
            end
            if (cpl_valid != 0) begin
                if (exp_cpl.size() == 0) check("cpl_unexpected", cpl_valid, 0);
                else begin
                    ep = exp_cpl.pop_front();
                    check("cpl_valid", cpl_valid, ep.vld);
                    check("cpl_status", cpl_status, ep.st);
                    check("cpl_latency", cyc - last_grant, ep.lat);
                end
            end
            if (dma_abort) begin
                aborts++;
                check("abort_pulse_width", prev_abort, 0);
                check("abort_delay", cyc - wait_start, TO);
            end
        end
        prev_abort = dma_abort;
        prev_valid = dma_cmd_valid;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        req_valid = '0;
        req_src   = '0;
        req_dst   = '0;
        req_len   = '0;
        tick(2);
        check("rst_req_ready", req_ready, 0);
        check("rst_cmd_valid", dma_cmd_valid, 0);
        check("rst_dma_fields", {dma_src, dma_dst, dma_len}, 0);
        check("rst_abort", dma_abort, 0);
        check("rst_cpl", {cpl_valid, cpl_status}, 0);
        check("rst_busy_owner", {busy, owner}, 0);
        rst_n = 1'b1;
        tick(1);

        // single command from initiator 2, ready after 3 cycles, done 10 into WAIT
        ready_dly = 3;
        done_dly  = 10;
        set_cmd(2, 32'h0000_1000, 32'h0000_2000, 16'd64);
        push_cmd(32'h0000_1000, 32'h0000_2000, 16'd64);
        push_cpl(4'b0100, 2'b00, 16);
        serve(4'b0100, 1, 0);
        drain("single", 60);

        // all four continuously requesting from pointer 0
        do_reset();
        ready_dly = 0;
        done_dly  = 0;
        for (int i = 0; i < N; i++) set_cmd(i, srcs[i], dsts[i], lens[i]);
        for (int k = 0; k < 5; k++) begin
            push_cmd(srcs[ord[k]], dsts[ord[k]], lens[ord[k]]);
            push_cpl(4'(1 << ord[k]), 2'b00, 3);
        end
        gnt_log.delete();
        serve(4'b1111, 5, 1);
        drain("round_robin", 100);
        check("rr_grant_count", gnt_log.size(), 5);
        for (int k = 0; k < 5; k++) check("rr_grant_order", (k < gnt_log.size()) ? gnt_log[k] : -1, ord[k]);

        // initiator 1, done withheld -> abort and timeout status
        withhold = 1'b1;
        set_cmd(1, 32'h0000_3000, 32'h0000_4000, 16'd32);
        push_cmd(32'h0000_3000, 32'h0000_4000, 16'd32);
        push_cpl(4'b0010, 2'b10, 19);
        exp_aborts++;
        serve(4'b0010, 1, 0);
        drain("timeout", 80);
        withhold = 1'b0;
        check("abort_count_timeout", aborts, exp_aborts);

        // initiator 0, done with error
        err_flag = 1'b1;
        done_dly = 2;
        set_cmd(0, 32'h0000_5000, 32'h0000_6000, 16'd128);
        push_cmd(32'h0000_5000, 32'h0000_6000, 16'd128);
        push_cpl(4'b0001, 2'b01, 5);
        serve(4'b0001, 1, 0);
        drain("dma_error", 60);
        err_flag = 1'b0;

        // initiator 3, zero length: no DMA command
        set_cmd(3, 32'h0000_7000, 32'h0000_8000, 16'd0);
        push_cpl(4'b1000, 2'b00, 1);
        serve(4'b1000, 1, 0);
        drain("zero_len", 20);

        // initiator 1, done with error on the last WAIT cycle: done wins
        err_flag = 1'b1;
        done_dly = 15;
        set_cmd(1, 32'h0000_9000, 32'h0000_9800, 16'd4);
        push_cmd(32'h0000_9000, 32'h0000_9800, 16'd4);
        push_cpl(4'b0010, 2'b01, 18);
        serve(4'b0010, 1, 0);
        drain("done_at_timeout", 80);
        err_flag = 1'b0;
        done_dly = 0;
        check("abort_count_edge", aborts, exp_aborts);

        // reset in WAIT: outputs clear at once, no completion or abort follows
        withhold = 1'b1;
        set_cmd(2, 32'h0000_C000, 32'h0000_D000, 16'd256);
        push_cmd(32'h0000_C000, 32'h0000_D000, 16'd256);
        serve(4'b0100, 1, 0);
        tick(5);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy_owner", {busy, owner}, 0);
        check("mid_rst_dma_fields", {dma_src, dma_dst, dma_len}, 0);
        check("mid_rst_abort_cpl", {dma_abort, cpl_valid, cpl_status}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(25);
        withhold = 1'b0;
        check("abort_count_rst", aborts, exp_aborts);

        // pointer restarts at 0: initiator 1 before initiator 3
        set_cmd(1, 32'h0000_E000, 32'h0000_E100, 16'd0);
        set_cmd(3, 32'h0000_F000, 32'h0000_F100, 16'd0);
        push_cpl(4'b0010, 2'b00, 1);
        push_cpl(4'b1000, 2'b00, 1);
        gnt_log.delete();
        serve(4'b1010, 2, 0);
        drain("post_reset", 30);
        check("post_rst_grant_count", gnt_log.size(), 2);
        check("post_rst_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
        check("post_rst_second_grant", (gnt_log.size() > 1) ? gnt_log[1] : -1, 3);

        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("abort_count_final", aborts, exp_aborts);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
